isr_queue: RTL and testbench

//  Parametrised instruction-staging queue between memory bus (M_BUS) and the

---
 rtl/isr_queue.sv | 90 +++++++++
 tb/tb_isr_queue.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/isr_queue.sv
// Instruction-staging FIFO between the memory bus and the decoder.
// Show-ahead head word, synchronous flush and a sticky overflow flag.
module isr_queue #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             MIS,
  input  logic [WIDTH-1:0] M_BUS,
  input  logic             ISR_RD,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] ISR,
  output logic             ISR_VALID,
  output logic             FULL,
  output logic [CW-1:0]    COUNT,
  output logic             OVF
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: a word transfers in on a CLK edge when MIS is high and the queue
  // can accept it (not FULL, or a pop frees a slot on the same edge); the head
  // word transfers out when ISR_RD is high and ISR_VALID is high. ISR_RD on an
  // empty queue and MIS into a full queue without a pop are both ignored.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             ovf_q,    ovf_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic wr_en;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    pop      = ISR_RD & ~empty;
    push     = MIS & (~full | pop);
    wr_en    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      wr_en = push;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (MIS && !push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; stale contents are masked by ISR_VALID.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= M_BUS;
  end

  assign ISR_VALID = ~empty;
  assign ISR       = empty ? '0 : mem_q[rd_ptr_q];
  assign FULL      = full;
  assign COUNT     = count_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_isr_queue.sv
// Directed and random stimulus for isr_queue, checked against a queue model.
module tb_isr_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             CLK;
  logic             CLR;
  logic             MIS;
  logic [WIDTH-1:0] M_BUS;
  logic             ISR_RD;
  logic             FLUSH;
  logic [WIDTH-1:0] ISR;
  logic             ISR_VALID;
  logic             FULL;
  logic [CW-1:0]    COUNT;
  logic             OVF;

  isr_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .CLR(CLR), .MIS(MIS), .M_BUS(M_BUS), .ISR_RD(ISR_RD),
    .FLUSH(FLUSH), .ISR(ISR), .ISR_VALID(ISR_VALID), .FULL(FULL),
    .COUNT(COUNT), .OVF(OVF)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_ovf;
  int               n_checks = 0;
  int               n_pass   = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [WIDTH-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check({tag, ".count"}, 32'(COUNT), 32'(exp_q.size()));
    check({tag, ".valid"}, 32'(ISR_VALID), 32'(exp_q.size() != 0));
    check({tag, ".full"},  32'(FULL), 32'(exp_q.size() == DEPTH));
    check({tag, ".ovf"},   32'(OVF), 32'(exp_ovf));
    check({tag, ".isr"},   32'(ISR), 32'(head));
  endtask

  // ---------------- driver ----------------
  // Drives one cycle, advances the model on pre-edge state, checks after the edge.
  task automatic cycle(input string tag, input logic mis, input logic [WIDTH-1:0] data,
                       input logic rd, input logic flush);
    logic was_full, was_empty, do_pop, do_push;
    MIS = mis; M_BUS = data; ISR_RD = rd; FLUSH = flush;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    if (flush) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      do_pop  = rd && !was_empty;
      do_push = mis && (!was_full || do_pop);
      if (do_pop) begin
        check({tag, ".pop_word"}, 32'(ISR), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (do_push) exp_q.push_back(data);
      if (mis && !do_push) exp_ovf = 1'b1;
    end
    @(posedge CLK);
    #1;
    MIS = 1'b0; ISR_RD = 1'b0; FLUSH = 1'b0;
    check_state(tag);
  endtask

  task automatic push(input string tag, input logic [WIDTH-1:0] data);
    cycle(tag, 1'b1, data, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag);
    cycle(tag, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic fill_a;
    for (int i = 1; i <= DEPTH; i++) push("fill", WIDTH'(16'hA000 + i));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_ovf = 1'b0;
    CLR = 1'b0; MIS = 1'b1; M_BUS = 16'hFFFF; ISR_RD = 1'b0; FLUSH = 1'b0;

    // 1: reset holds state at zero even with MIS asserted
    #1;
    check_state("reset_async");
    repeat (3) begin
      @(posedge CLK); #1;
      check_state("reset_hold");
    end
    MIS = 1'b0;
    CLR = 1'b1;
    push("first_push", 16'h1234);
    pop("first_pop");

    // 2: fill / drain order
    fill_a();
    for (int i = 0; i < DEPTH; i++) pop("drain");

    // 3: overflow then flush clears it
    fill_a();
    cycle("overflow", 1'b1, 16'hBEEF, 1'b0, 1'b0);
    cycle("overflow_idle", 1'b0, '0, 1'b0, 1'b0);
    cycle("flush_ovf", 1'b0, '0, 1'b0, 1'b1);

    // 4: push+pop while full
    fill_a();
    cycle("full_pushpop", 1'b1, 16'hC005, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) pop("full_drain");

    // 5: flush beats push and pop
    push("pre_flush", 16'h1111);
    push("pre_flush", 16'h2222);
    cycle("flush_prio", 1'b1, 16'hD00D, 1'b1, 1'b1);
    push("post_flush", 16'h0042);
    pop("post_flush_pop");

    // 6: steady push+pop across pointer wrap, then read on empty
    push("wrap_seed", 16'h5000);
    for (int i = 1; i <= 10; i++) cycle("wrap", 1'b1, WIDTH'(16'h5000 + i), 1'b1, 1'b0);
    pop("wrap_last");
    pop("rd_empty");
    cycle("pushpop_empty", 1'b1, 16'h7777, 1'b1, 1'b0);
    pop("pushpop_empty_drain");

    // asynchronous reset in the middle of traffic
    push("pre_reset", 16'h9001);
    push("pre_reset", 16'h9002);
    cycle("pre_reset_ovf", 1'b0, '0, 1'b0, 1'b0);
    #3;
    CLR = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    check_state("reset_mid");
    @(posedge CLK); #1;
    CLR = 1'b1;
    push("after_reset", 16'h0ABC);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      cycle("random", 1'($urandom_range(0, 2) != 0), WIDTH'($urandom_range(0, 16'hFFFF)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0));
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
